out_buf_ctrl: RTL and testbench

- Output-buffer responder to the training-phase controller's buffer selects (buf_input_select, buf_output_select) and PE reset (pe_rst).
- Captures result words from the systolic array (SA) or batch-norm unit (BN) during a phase.
- At phase completion, drains the words in order to the input prefetcher (IP) or the weight prefetcher (WP) with a valid/ready handshake.
- Sits between SA/BN outputs and the prefetchers.

---
 rtl/out_buf_pkg.sv | 22 ++
 rtl/out_buf_mem.sv | 27 ++
 rtl/out_buf_ctrl.sv | 176 +++++++++++++++++
 tb/tb_out_buf_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_buf_pkg.sv
// Shared types and constants for the output-buffer controller slice.
package out_buf_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_DEPTH  = 16;

    // Controller states; the unused 2'b11 encoding recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        DRAIN   = 2'b10
    } state_e;

    // Capture source select encodings
    localparam logic SRC_SA = 1'b0;
    localparam logic SRC_BN = 1'b1;

    // Drain destination select encodings
    localparam logic DST_IP = 1'b0;
    localparam logic DST_WP = 1'b1;

endpackage

// File: rtl/out_buf_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one
// asynchronous read port. Contents are never reset.
module out_buf_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store one word per cycle when the controller asks for it
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/out_buf_ctrl.sv
// Output-buffer controller: captures SA or BN result words during a
// training phase and drains them in order to the IP or WP prefetcher.
module out_buf_ctrl
    import out_buf_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              fsm_rst_n,
    input  logic              buf_input_select,
    input  logic              buf_output_select,
    input  logic              pe_rst,
    input  logic [DATA_W-1:0] sa_data,
    input  logic              sa_valid,
    input  logic [DATA_W-1:0] bn_data,
    input  logic              bn_valid,
    output logic [DATA_W-1:0] ip_data,
    output logic              ip_valid,
    input  logic              ip_ready,
    output logic [DATA_W-1:0] wp_data,
    output logic              wp_valid,
    input  logic              wp_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    state_e            state_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              src_sel_q;
    logic              dst_sel_q;
    logic              pe_rst_q;
    logic              overflow_q;

    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              live_valid;
    logic [DATA_W-1:0] live_data;
    logic              done_evt;
    logic              full_w;
    logic              idle_wr;
    logic              cap_wr;
    logic              cap_last;
    logic [CNT_W-1:0]  cap_cnt;
    logic              in_drain;
    logic              sel_ready;
    logic              beat;
    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_data;

    // Latched source for CAPTURE; the live select only matters for the
    // very first word, which is taken while still in IDLE.
    assign sel_valid  = (src_sel_q == SRC_BN) ? bn_valid : sa_valid;
    assign sel_data   = (src_sel_q == SRC_BN) ? bn_data  : sa_data;
    assign live_valid = (buf_input_select == SRC_BN) ? bn_valid : sa_valid;
    assign live_data  = (buf_input_select == SRC_BN) ? bn_data  : sa_data;

    assign done_evt = pe_rst_q & ~pe_rst;
    assign full_w   = (count_q == CNT_W'(DEPTH));

    assign idle_wr  = (state_q == IDLE) & live_valid;
    assign cap_wr   = (state_q == CAPTURE) & sel_valid & ~full_w;
    assign cap_cnt  = count_q + CNT_W'(cap_wr);
    // Filling the last free slot ends the phase without waiting for pe_rst.
    assign cap_last = cap_wr & (count_q == CNT_W'(DEPTH - 1));

    assign in_drain  = (state_q == DRAIN);
    assign sel_ready = (dst_sel_q == DST_WP) ? wp_ready : ip_ready;
    assign beat      = in_drain & sel_ready;

    assign mem_we    = idle_wr | cap_wr;
    assign mem_waddr = idle_wr ? '0 : wr_ptr_q;
    assign mem_wdata = idle_wr ? live_data : sel_data;

    out_buf_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Phase controller: capture, then drain in order, then back to idle
    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            src_sel_q  <= 1'b0;
            dst_sel_q  <= 1'b0;
            pe_rst_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pe_rst_q <= pe_rst;
            case (state_q)
                IDLE: begin
                    src_sel_q <= buf_input_select;
                    if (idle_wr) begin
                        wr_ptr_q <= PTR_W'(1);
                        count_q  <= CNT_W'(1);
                        state_q  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (cap_wr) begin
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    end
                    if (sel_valid & full_w) begin
                        overflow_q <= 1'b1;
                    end
                    count_q <= cap_cnt;
                    // A word arriving with done_evt is kept before switching.
                    if (done_evt | cap_last) begin
                        dst_sel_q <= buf_output_select;
                        if (cap_cnt != '0) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q  <= IDLE;
                            wr_ptr_q <= '0;
                            rd_ptr_q <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // Nothing is accepted while draining.
                    if (sa_valid | bn_valid) begin
                        overflow_q <= 1'b1;
                    end
                    if (beat) begin
                        if (count_q == CNT_W'(1)) begin
                            state_q  <= IDLE;
                            wr_ptr_q <= '0;
                            rd_ptr_q <= '0;
                            count_q  <= '0;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                            count_q  <= count_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end
            endcase
        end
    end

    // Only the latched destination sees valid/data; the other port idles at zero.
    assign ip_valid = in_drain & (dst_sel_q == DST_IP);
    assign wp_valid = in_drain & (dst_sel_q == DST_WP);
    assign ip_data  = ip_valid ? rd_data : '0;
    assign wp_data  = wp_valid ? rd_data : '0;

    assign count    = count_q;
    assign full     = full_w;
    assign empty    = (count_q == '0);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_out_buf_ctrl.sv
// Self-checking bench for out_buf_ctrl: table-driven phases, hand-written
// corner sequences and randomized phases against a queue-level model.
module tb_out_buf_ctrl;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              fsm_rst_n;
    logic              buf_input_select;
    logic              buf_output_select;
    logic              pe_rst;
    logic [DATA_W-1:0] sa_data;
    logic              sa_valid;
    logic [DATA_W-1:0] bn_data;
    logic              bn_valid;
    logic [DATA_W-1:0] ip_data;
    logic              ip_valid;
    logic              ip_ready;
    logic [DATA_W-1:0] wp_data;
    logic              wp_valid;
    logic              wp_ready;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              overflow;

    always #5 clk = ~clk;

    out_buf_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .fsm_rst_n         (fsm_rst_n),
        .buf_input_select  (buf_input_select),
        .buf_output_select (buf_output_select),
        .pe_rst            (pe_rst),
        .sa_data           (sa_data),
        .sa_valid          (sa_valid),
        .bn_data           (bn_data),
        .bn_valid          (bn_valid),
        .ip_data           (ip_data),
        .ip_valid          (ip_valid),
        .ip_ready          (ip_ready),
        .wp_data           (wp_data),
        .wp_valid          (wp_valid),
        .wp_ready          (wp_ready),
        .count             (count),
        .full              (full),
        .empty             (empty),
        .overflow          (overflow)
    );

    int checks   = 0;
    int failures = 0;
    int rdy_mode = 0;
    int pidx     = 0;
    bit ovf_exp;

    logic [DATA_W-1:0] got_ip[$];
    logic [DATA_W-1:0] got_wp[$];
    logic [DATA_W-1:0] exp_q[$];

    logic              ip_hold, wp_hold;
    logic [DATA_W-1:0] ip_hold_d, wp_hold_d;

    typedef struct {
        bit          src;
        bit          dst;
        int          n;
        logic [15:0] base;
        logic [15:0] stp;
        int          rmode;
        bit          inject;
        bit          last_done;
        bit          exp_ovf;
        int          exp_beats;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Ready generator: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1
    initial begin
        logic [3:0] pat;
        pat      = 4'b1001;
        ip_ready = 1'b1;
        wp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: begin
                    ip_ready = 1'b1;
                    wp_ready = 1'b1;
                end
                1: begin
                    ip_ready = 1'($urandom_range(0, 1));
                    wp_ready = 1'($urandom_range(0, 1));
                end
                default: begin
                    ip_ready = pat[pidx];
                    wp_ready = pat[pidx];
                    pidx     = (pidx + 1) % 4;
                end
            endcase
        end
    end

    // Beat monitor with hold-stability and idle-port checks
    always @(negedge clk) begin
        if (!fsm_rst_n) begin
            ip_hold = 1'b0;
            wp_hold = 1'b0;
        end else begin
            if (ip_hold) begin
                chk("ip_hold_valid", 32'(ip_valid), 1);
                chk("ip_hold_data", 32'(ip_data), 32'(ip_hold_d));
            end
            if (wp_hold) begin
                chk("wp_hold_valid", 32'(wp_valid), 1);
                chk("wp_hold_data", 32'(wp_data), 32'(wp_hold_d));
            end
            if (!ip_valid) chk("ip_idle_data", 32'(ip_data), 0);
            if (!wp_valid) chk("wp_idle_data", 32'(wp_data), 0);
            if (ip_valid && ip_ready) got_ip.push_back(ip_data);
            if (wp_valid && wp_ready) got_wp.push_back(wp_data);
            ip_hold   = ip_valid && !ip_ready;
            ip_hold_d = ip_data;
            wp_hold   = wp_valid && !wp_ready;
            wp_hold_d = wp_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        pe_rst            = 1'b0;
        buf_input_select  = 1'b0;
        buf_output_select = 1'b0;
        sa_valid          = 1'b0;
        bn_valid          = 1'b0;
        sa_data           = '0;
        bn_data           = '0;
    endtask

    task automatic do_reset();
        fsm_rst_n = 1'b0;
        clear_inputs();
        step_clk();
        step_clk();
        fsm_rst_n = 1'b1;
        step_clk();
        got_ip.delete();
        got_wp.delete();
        exp_q.delete();
    endtask

    // One capture phase; the model keeps the first DEPTH words of the selected source.
    task automatic run_phase(input bit src, input bit dst, input int n, input logic [15:0] base,
                             input logic [15:0] stp, input bit inject, input bit rnd, input bit last_done);
        logic [15:0] w;
        buf_input_select  = src;
        buf_output_select = dst;
        pe_rst            = 1'b1;
        step_clk();
        for (int i = 0; i < n; i++) begin
            w = base + stp * 16'(i);
            if (src) begin
                bn_valid = 1'b1;  bn_data = w;
                sa_valid = inject && (i < DEPTH);  sa_data = ~w;
            end else begin
                sa_valid = 1'b1;  sa_data = w;
                bn_valid = inject && (i < DEPTH);  bn_data = ~w;
            end
            if (i < DEPTH) exp_q.push_back(w);
            if (last_done && n < DEPTH && i == n - 1) pe_rst = 1'b0;
            step_clk();
            sa_valid = 1'b0;
            bn_valid = 1'b0;
            if (rnd) buf_input_select = 1'($urandom_range(0, 1));
            if (i == DEPTH - 1) begin
                chk("full_count", 32'(count), DEPTH);
                chk("full_flag", 32'(full), 1);
                chk("drain_first_valid", 32'(dst ? wp_valid : ip_valid), 1);
            end
            if (rnd && i < DEPTH - 1 && i < n - 1) repeat ($urandom_range(0, 2)) step_clk();
        end
        if (n < DEPTH) begin
            if (!last_done) begin
                pe_rst = 1'b0;
                step_clk();
            end
            chk("phase_count", 32'(count), 32'(n));
            chk("drain_first_valid", 32'(dst ? wp_valid : ip_valid), 1);
        end
        pe_rst = 1'b0;
    endtask

    task automatic finish_phase(input bit dst, input bit rnd, input int exp_beats, input bit exp_ovf);
        int k;
        k = 0;
        while (!(empty && !ip_valid && !wp_valid) && k < 400) begin
            if (rnd) buf_output_select = 1'($urandom_range(0, 1));
            step_clk();
            k++;
        end
        chk("drain_complete", 32'(k < 400), 1);
        chk("beat_count", 32'(dst ? got_wp.size() : got_ip.size()), 32'(exp_beats));
        chk("other_port_beats", 32'(dst ? got_ip.size() : got_wp.size()), 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (dst && i < got_wp.size()) chk("wp_beat_data", 32'(got_wp[i]), 32'(exp_q[i]));
            if (!dst && i < got_ip.size()) chk("ip_beat_data", 32'(got_ip[i]), 32'(exp_q[i]));
        end
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("empty_after", 32'(empty), 1);
        chk("count_after", 32'(count), 0);
        got_ip.delete();
        got_wp.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        bit s, d;
        tbl[0] = '{0, 0, 5,  16'h0011, 16'h0001, 0, 0, 0, 0, 5};
        tbl[1] = '{0, 0, 5,  16'h0011, 16'h0001, 2, 0, 0, 0, 5};
        tbl[2] = '{1, 1, 3,  16'hA0A0, 16'h1010, 0, 1, 0, 0, 3};
        tbl[3] = '{0, 0, 17, 16'h0100, 16'h0001, 1, 1, 0, 1, 16};
        tbl[4] = '{0, 1, 4,  16'h0200, 16'h0003, 0, 0, 1, 0, 4};

        // Reset state
        fsm_rst_n = 1'b0;
        clear_inputs();
        step_clk();
        chk("rst_ip_valid", 32'(ip_valid), 0);
        chk("rst_wp_valid", 32'(wp_valid), 0);
        chk("rst_ip_data", 32'(ip_data), 0);
        chk("rst_wp_data", 32'(wp_data), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_overflow", 32'(overflow), 0);
        fsm_rst_n = 1'b1;
        step_clk();

        // Table-driven phases
        for (int t = 0; t < 5; t++) begin
            do_reset();
            rdy_mode = tbl[t].rmode;
            run_phase(tbl[t].src, tbl[t].dst, tbl[t].n, tbl[t].base, tbl[t].stp,
                      tbl[t].inject, 1'b0, tbl[t].last_done);
            finish_phase(tbl[t].dst, 1'b0, tbl[t].exp_beats, tbl[t].exp_ovf);
            if (tbl[t].exp_ovf) begin
                repeat (5) step_clk();
                chk("overflow_sticky", 32'(overflow), 1);
            end
        end

        // Empty phase: pe_rst falls with nothing captured
        do_reset();
        rdy_mode = 0;
        pe_rst   = 1'b1;
        step_clk();
        pe_rst   = 1'b0;
        step_clk();
        for (int i = 0; i < 3; i++) begin
            chk("empty_phase_count", 32'(count), 0);
            chk("empty_phase_valid", 32'(ip_valid | wp_valid), 0);
            step_clk();
        end

        // Reset in the middle of a 6-word drain
        do_reset();
        rdy_mode = 0;
        run_phase(1'b0, 1'b0, 6, 16'h0300, 16'h0001, 1'b0, 1'b0, 1'b0);
        step_clk();
        step_clk();
        chk("middrain_beats_before", 32'(got_ip.size()), 2);
        fsm_rst_n = 1'b0;
        #1;
        chk("middrain_ip_valid", 32'(ip_valid), 0);
        chk("middrain_count", 32'(count), 0);
        chk("middrain_empty", 32'(empty), 1);
        step_clk();
        fsm_rst_n = 1'b1;
        repeat (5) step_clk();
        chk("middrain_no_more_beats", 32'(got_ip.size()), 2);
        chk("middrain_idle_valid", 32'(ip_valid | wp_valid), 0);

        // Randomized phases against the queue model
        do_reset();
        rdy_mode = 1;
        ovf_exp  = 1'b0;
        for (int p = 0; p < 25; p++) begin
            s = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(16, 19)) : int'($urandom_range(1, 15));
            run_phase(s, d, n, 16'($urandom), 16'($urandom_range(1, 255)),
                      1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
            if (n > DEPTH) ovf_exp = 1'b1;
            finish_phase(d, 1'b1, (n < DEPTH) ? n : DEPTH, ovf_exp);
            repeat ($urandom_range(0, 3)) step_clk();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
